// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with optional 2-entry skid buffer.
// Exceptions travel downstream as tagged bubbles (payload forced to NOP_VALUE).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held, o_valid_dn low
// ST_ONE   | head (main) entry valid
// ST_FULL  | main and skid both valid, upstream back-pressured
module pipe_stage_skid #(
    parameter int                 DATA_W    = 64,
    parameter int                 EXC_W     = 4,
    parameter logic [EXC_W-1:0]   EXC_NONE  = 4'hF,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter bit                 SKID_EN   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clk_en,
    input  logic              i_flush,
    input  logic              i_flush_exception,
    input  logic              i_valid_up,
    output logic              o_ready_up,
    input  logic [DATA_W-1:0] i_data_up,
    input  logic [EXC_W-1:0]  i_exc_up,
    output logic              o_valid_dn,
    input  logic              i_ready_dn,
    output logic [DATA_W-1:0] o_data_dn,
    output logic [EXC_W-1:0]  o_exc_dn,
    output logic [1:0]        o_occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [EXC_W-1:0]  main_exc;
    logic [DATA_W-1:0] skid_data;
    logic [EXC_W-1:0]  skid_exc;
    logic              ready_q;

    logic              push;
    logic              pop;
    logic              clear;
    logic [DATA_W-1:0] in_data;

    assign o_valid_dn  = (state != ST_EMPTY);
    assign o_data_dn   = main_data;
    assign o_exc_dn    = main_exc;
    assign o_occupancy = state;
    assign o_ready_up  = SKID_EN ? ready_q : (!o_valid_dn || i_ready_dn);

    assign push  = i_valid_up && o_ready_up && i_clk_en;
    assign pop   = o_valid_dn && i_ready_dn && i_clk_en;
    assign clear = !i_rst_n || i_flush || i_flush_exception;

    // Excepted entries carry no payload so commit sees a clean bubble.
    assign in_data = (i_exc_up != EXC_NONE) ? NOP_VALUE : i_data_up;

    always_ff @(posedge i_clk) begin
        if (clear) begin
            state     <= ST_EMPTY;
            main_data <= NOP_VALUE;
            main_exc  <= EXC_NONE;
            skid_data <= NOP_VALUE;
            skid_exc  <= EXC_NONE;
            ready_q   <= 1'b1;
        end else if (i_clk_en) begin
            unique case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state     <= ST_ONE;
                        main_data <= in_data;
                        main_exc  <= i_exc_up;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_data <= in_data;
                        main_exc  <= i_exc_up;
                    end else if (push && SKID_EN) begin
                        state     <= ST_FULL;
                        skid_data <= in_data;
                        skid_exc  <= i_exc_up;
                        ready_q   <= 1'b0;
                    end else if (pop) begin
                        state     <= ST_EMPTY;
                        main_data <= NOP_VALUE;
                        main_exc  <= EXC_NONE;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state     <= ST_ONE;
                        main_data <= skid_data;
                        main_exc  <= skid_exc;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    main_data <= NOP_VALUE;
                    main_exc  <= EXC_NONE;
                    ready_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one skid instance and one SKID_EN=0 instance.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic        flush_exc;
    logic        valid_up;
    logic [63:0] data_up;
    logic [3:0]  exc_up;
    logic        ready_dn;

    logic        ready_up,  ready_up0;
    logic        valid_dn,  valid_dn0;
    logic [63:0] data_dn,   data_dn0;
    logic [3:0]  exc_dn,    exc_dn0;
    logic [1:0]  occ,       occ0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.SKID_EN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
        .i_flush_exception(flush_exc), .i_valid_up(valid_up), .o_ready_up(ready_up),
        .i_data_up(data_up), .i_exc_up(exc_up), .o_valid_dn(valid_dn),
        .i_ready_dn(ready_dn), .o_data_dn(data_dn), .o_exc_dn(exc_dn),
        .o_occupancy(occ)
    );

    pipe_stage_skid #(.SKID_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
        .i_flush_exception(flush_exc), .i_valid_up(valid_up), .o_ready_up(ready_up0),
        .i_data_up(data_up), .i_exc_up(exc_up), .o_valid_dn(valid_dn0),
        .i_ready_dn(ready_dn), .o_data_dn(data_dn0), .o_exc_dn(exc_dn0),
        .o_occupancy(occ0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants checked every cycle once out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("no_push_full", 64'(occ == 2'd2 && valid_up && ready_up && clk_en), 64'd0);
            if (exc_dn !== 4'hF) chk("exc_nop", data_dn, 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; clk_en = 1; flush = 0; flush_exc = 0;
        valid_up = 1; data_up = 64'hAAAA; exc_up = 4'hF; ready_dn = 0;

        // reset
        tick(); tick();
        chk("rst_valid", 64'(valid_dn), 64'd0);
        chk("rst_data", data_dn, 64'd0);
        chk("rst_exc", 64'(exc_dn), 64'hF);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_ready", 64'(ready_up), 64'd1);
        rst_n = 1; valid_up = 0;

        // streaming
        ready_dn = 1; valid_up = 1;
        data_up = 64'h1; tick();
        chk("str1_data", data_dn, 64'h1);
        chk("str1_occ", 64'(occ), 64'd1);
        data_up = 64'h2; tick();
        chk("str2_data", data_dn, 64'h2);
        chk("str2_valid", 64'(valid_dn), 64'd1);
        data_up = 64'h3; tick();
        chk("str3_data", data_dn, 64'h3);
        chk("str3_occ", 64'(occ), 64'd1);
        chk("str3_ready", 64'(ready_up), 64'd1);
        valid_up = 0; tick();
        chk("str_drain_occ", 64'(occ), 64'd0);

        // stall into skid
        ready_dn = 0; valid_up = 1;
        data_up = 64'h11; tick();
        chk("stall_a_occ", 64'(occ), 64'd1);
        chk("stall_a_ready", 64'(ready_up), 64'd1);
        data_up = 64'h22; tick();
        chk("stall_full_occ", 64'(occ), 64'd2);
        chk("stall_full_ready", 64'(ready_up), 64'd0);
        chk("stall_full_head", data_dn, 64'h11);
        valid_up = 0; ready_dn = 1; tick();
        chk("stall_pop1_data", data_dn, 64'h22);
        chk("stall_pop1_occ", 64'(occ), 64'd1);
        chk("stall_pop1_ready", 64'(ready_up), 64'd1);
        tick();
        chk("stall_pop2_occ", 64'(occ), 64'd0);

        // exception tag
        valid_up = 1; data_up = 64'h1234; exc_up = 4'h1; tick();
        chk("exc_valid", 64'(valid_dn), 64'd1);
        chk("exc_code", 64'(exc_dn), 64'h1);
        chk("exc_data", data_dn, 64'd0);
        data_up = 64'h55; exc_up = 4'hF; tick();
        chk("exc_next_data", data_dn, 64'h55);
        chk("exc_next_code", 64'(exc_dn), 64'hF);
        valid_up = 0; tick();

        // flush while full, push and clock enable low on the same cycle
        for (int k = 0; k < 2; k++) begin
            ready_dn = 0; valid_up = 1;
            data_up = 64'h66; tick();
            data_up = 64'h77; tick();
            chk("fl_pre_occ", 64'(occ), 64'd2);
            data_up = 64'h9; clk_en = 0;
            if (k == 0) flush = 1; else flush_exc = 1;
            tick();
            chk("fl_occ", 64'(occ), 64'd0);
            chk("fl_valid", 64'(valid_dn), 64'd0);
            chk("fl_ready", 64'(ready_up), 64'd1);
            chk("fl_data", data_dn, 64'd0);
            flush = 0; flush_exc = 0; clk_en = 1; valid_up = 0; ready_dn = 1;
            tick();
            chk("fl_after_valid", 64'(valid_dn), 64'd0);
            chk("fl_after_data", data_dn, 64'd0);
        end

        // clock enable freeze
        ready_dn = 0; valid_up = 1; data_up = 64'h88; tick();
        chk("ce_pre_occ", 64'(occ), 64'd1);
        clk_en = 0;
        for (int i = 0; i < 3; i++) begin
            valid_up = i[0]; ready_dn = !i[0]; data_up = 64'h99 + 64'(i);
            tick();
            chk("ce_data", data_dn, 64'h88);
            chk("ce_occ", 64'(occ), 64'd1);
            chk("ce_valid", 64'(valid_dn), 64'd1);
        end
        clk_en = 1; valid_up = 0; ready_dn = 1; tick();
        chk("ce_drain_occ", 64'(occ), 64'd0);

        // single-entry mode
        rst_n = 0; tick(); rst_n = 1;
        ready_dn = 0; valid_up = 1; data_up = 64'hA1; #1;
        chk("ns_ready_empty", 64'(ready_up0), 64'd1);
        tick();
        chk("ns_occ1", 64'(occ0), 64'd1);
        chk("ns_ready_stall", 64'(ready_up0), 64'd0);
        data_up = 64'hA2; tick();
        chk("ns_hold_occ", 64'(occ0), 64'd1);
        chk("ns_hold_data", data_dn0, 64'hA1);
        ready_dn = 1; #1;
        chk("ns_ready_comb", 64'(ready_up0), 64'd1);
        tick();
        chk("ns_pp_data", data_dn0, 64'hA2);
        chk("ns_pp_occ", 64'(occ0), 64'd1);
        valid_up = 0; tick();
        chk("ns_drain_occ", 64'(occ0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
